// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_direct_mapped #(
   parameter int DATA_WIDTH = 32,
   parameter int SET_BITS   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic                  cpu_byte,
   input  logic [31:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wd,
   output logic [DATA_WIDTH-1:0] cpu_rd,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  mem_st_byte,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd,
   input  logic                  mem_ready,
`ifdef DCACHE_STATS_EN
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses,
`endif
   output logic [1:0]            dbg_state
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = 30 - SET_BITS;

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("dcache_direct_mapped: DATA_WIDTH must be 32");
   end

   // Handshake: cpu_req is held stable while cpu_stall=1; the request completes in
   // the first cycle with cpu_req=1 and cpu_stall=0. A memory access completes in
   // the cycle where mem_req=1 and mem_ready=1; mem_ready is ignored otherwise.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [SETS-1:0]       r_valid;
   logic [TAG_W-1:0]      r_tag  [SETS];
   logic [DATA_WIDTH-1:0] r_data [SETS];
   logic [DATA_WIDTH-1:0] r_rd_cap;

   logic [SET_BITS-1:0]   w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_hit;
   logic [4:0]            w_lane;
   logic                  w_load;

   assign w_idx     = cpu_addr[2 +: SET_BITS];
   assign w_tag     = cpu_addr[31 -: TAG_W];
   assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_lane    = {cpu_addr[1:0], 3'b000};
   assign w_load    = cpu_req && !cpu_we;
   assign dbg_state = r_state;

   function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [DATA_WIDTH-1:0] word,
                                                      input logic byte_acc,
                                                      input logic [4:0] lane);
      if (byte_acc) fmt_load = {{(DATA_WIDTH-8){1'b0}}, word[lane +: 8]};
      else          fmt_load = word;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_valid  <= '0;
         r_rd_cap <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == FILL && mem_ready) begin
            r_valid[w_idx] <= 1'b1;
            r_tag[w_idx]   <= w_tag;
            r_data[w_idx]  <= mem_rd;
            r_rd_cap       <= fmt_load(mem_rd, cpu_byte, w_lane);
         end
         // Write-through keeps a resident line coherent; misses never allocate.
         if (r_state == WRITE && mem_ready && w_hit) begin
            if (cpu_byte) r_data[w_idx][w_lane +: 8] <= cpu_wd[7:0];
            else          r_data[w_idx]              <= cpu_wd;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      cpu_stall   = 1'b0;
      cpu_rd      = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_st_byte = 1'b0;
      mem_addr    = '0;
      mem_wd      = '0;
      case (r_state)
         IDLE: begin
            if (cpu_req) begin
               if (cpu_we) begin
                  cpu_stall = 1'b1;
                  w_next    = WRITE;
               end else if (w_hit) begin
                  cpu_rd = fmt_load(r_data[w_idx], cpu_byte, w_lane);
               end else begin
                  cpu_stall = 1'b1;
                  w_next    = FILL;
               end
            end
         end
         FILL: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {cpu_addr[31:2], 2'b00};
            if (mem_ready) w_next = DONE;
         end
         WRITE: begin
            cpu_stall   = 1'b1;
            mem_req     = 1'b1;
            mem_we      = 1'b1;
            mem_st_byte = cpu_byte;
            mem_addr    = cpu_addr;
            mem_wd      = cpu_wd;
            if (mem_ready) w_next = DONE;
         end
         DONE: begin
            if (!cpu_we) cpu_rd = r_rd_cap;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hits;
   logic [31:0] r_misses;

   assign stat_hits   = r_hits;
   assign stat_misses = r_misses;

   // A miss is counted when its load finishes, so aborted fills never count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hits   <= '0;
         r_misses <= '0;
      end else begin
         if (r_state == IDLE && w_load && w_hit && r_hits != 32'hFFFF_FFFF)
            r_hits <= r_hits + 32'd1;
         if (r_state == DONE && w_load && r_misses != 32'hFFFF_FFFF)
            r_misses <= r_misses + 32'd1;
      end
   end
`endif

endmodule
